// File: rtl/uart_fifo_pkg.sv
// Shared constants and types for the UART watermark FIFO.
// The optional sticky error flags are enabled with UART_FIFO_ERR_FLAGS_EN.
package uart_fifo_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_WIDTH = 8;

  // Width needed to count 0..depth inclusive.
  function automatic int clog2_depth(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH storage array for the UART FIFO: one synchronous write
// port and one asynchronous read port.
module uart_fifo_mem
  import uart_fifo_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; clearing it would stop it mapping onto RAM
  // and nothing reads an entry before it has been written.
  // NOTE: sequential state is always assigned with <= so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_wm_fifo.sv
// UART TX/RX buffer: synchronous FIFO of any DEPTH >= 2 with watermarks,
// occupancy level, flush and FWFT/registered read modes. UART_FIFO_ERR_FLAGS_EN adds sticky error flags.
module uart_wm_fifo
  import uart_fifo_pkg::*;
#(
  parameter  int DEPTH    = DEFAULT_DEPTH,
  parameter  int WIDTH    = DEFAULT_WIDTH,
  parameter  int AF_LEVEL = 12,
  parameter  int AE_LEVEL = 4,
  parameter  bit FWFT     = 1'b1,
  localparam int LW       = clog2_depth(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
`ifdef UART_FIFO_ERR_FLAGS_EN
  input  logic             err_clr,
  output logic             overflow,
  output logic             underflow,
`endif
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [LW-1:0]    level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AE_L    = LW'(AE_LEVEL);

  typedef logic [AW-1:0] ptr_t;

  if (DEPTH < 2 || AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL >= DEPTH)
  begin : g_bad_params
    $error("uart_wm_fifo: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  ptr_t            wr_ptr;
  ptr_t            rd_ptr;
  logic [LW-1:0]   level_q;
  logic            wr_acc;
  logic            rd_acc;
  logic [WIDTH-1:0] mem_rdata;
  fifo_status_t    status;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Every flag is a decode of the registered level, never of this cycle's requests.
  assign status = '{full:         (level_q == DEPTH_L),
                    empty:        (level_q == '0),
                    almost_full:  (level_q >= AF_L),
                    almost_empty: (level_q <= AE_L)};

  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;
  assign level        = level_q;

  assign wr_acc = wr_en & ~status.full  & ~flush;
  assign rd_acc = rd_en & ~status.empty & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  if (FWFT) begin : g_fwft
    assign rd_data  = mem_rdata;
    assign rd_valid = ~status.empty;
  end else begin : g_reg_out
    // rd_data keeps the last popped entry between reads.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) rd_data <= mem_rdata;
      end
    end
  end

`ifdef UART_FIFO_ERR_FLAGS_EN
  // A new event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en & status.full & ~flush) overflow <= 1'b1;
      else if (err_clr)                 overflow <= 1'b0;
      if (rd_en & status.empty & ~flush) underflow <= 1'b1;
      else if (err_clr)                  underflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_wm_fifo.sv
// Self-checking bench for uart_wm_fifo: three configurations share one stimulus
// stream and are compared every cycle against a queue-based reference model.
module tb_uart_wm_fifo;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       wr_en;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] wr_data;

  // u0: DEPTH 5 FWFT, u1: DEPTH 16 FWFT, u2: DEPTH 7 registered output
  logic [7:0] a_rd_data, b_rd_data, c_rd_data;
  logic       a_rd_valid, b_rd_valid, c_rd_valid;
  logic       a_full, b_full, c_full;
  logic       a_empty, b_empty, c_empty;
  logic       a_af, b_af, c_af;
  logic       a_ae, b_ae, c_ae;
  logic [2:0] a_level;
  logic [4:0] b_level;
  logic [2:0] c_level;
`ifdef UART_FIFO_ERR_FLAGS_EN
  logic       a_ovf, b_ovf, c_ovf;
  logic       a_unf, b_unf, c_unf;
`endif

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // Reference model: each FIFO is an ordered list, element 0 is the head.
  int         mdep [N];
  int         maf  [N];
  int         mae  [N];
  int         mcnt [N];
  logic [7:0] mdat [N][16];
  logic       m_ovf [N];
  logic       m_unf [N];
  logic       c_exp_v;
  logic [7:0] c_exp_d;

  always #5 clk = ~clk;

  uart_wm_fifo #(.DEPTH(5), .WIDTH(8), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
`ifdef UART_FIFO_ERR_FLAGS_EN
    .err_clr(err_clr), .overflow(a_ovf), .underflow(a_unf),
`endif
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(a_rd_data),
    .rd_valid(a_rd_valid), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .level(a_level)
  );

  uart_wm_fifo #(.DEPTH(16), .WIDTH(8), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
`ifdef UART_FIFO_ERR_FLAGS_EN
    .err_clr(err_clr), .overflow(b_ovf), .underflow(b_unf),
`endif
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .level(b_level)
  );

  uart_wm_fifo #(.DEPTH(7), .WIDTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(flush),
`ifdef UART_FIFO_ERR_FLAGS_EN
    .err_clr(err_clr), .overflow(c_ovf), .underflow(c_unf),
`endif
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(c_rd_data),
    .rd_valid(c_rd_valid), .full(c_full), .empty(c_empty),
    .almost_full(c_af), .almost_empty(c_ae), .level(c_level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < N; d++) begin
      mcnt[d]  = 0;
      m_ovf[d] = 1'b0;
      m_unf[d] = 1'b0;
    end
    c_exp_v = 1'b0;
    c_exp_d = 8'h00;
  endtask

  // Apply the inputs present at the edge just taken.
  task automatic model_update();
    bit         wa, ra;
    logic [7:0] head;
    for (int d = 0; d < N; d++) begin
      wa   = wr_en && (mcnt[d] < mdep[d]) && !flush;
      ra   = rd_en && (mcnt[d] > 0) && !flush;
      head = mdat[d][0];
      if (wr_en && (mcnt[d] == mdep[d]) && !flush) m_ovf[d] = 1'b1;
      else if (err_clr)                            m_ovf[d] = 1'b0;
      if (rd_en && (mcnt[d] == 0) && !flush)       m_unf[d] = 1'b1;
      else if (err_clr)                            m_unf[d] = 1'b0;
      if (flush) begin
        mcnt[d] = 0;
      end else begin
        if (ra) begin
          for (int k = 0; k < 15; k++) mdat[d][k] = mdat[d][k+1];
          mcnt[d]--;
        end
        if (wa) begin
          mdat[d][mcnt[d]] = wr_data;
          mcnt[d]++;
        end
      end
      if (d == 2) begin
        c_exp_v = ra;
        if (ra) c_exp_d = head;
      end
    end
  endtask

  task automatic cmp(input int d, input int lvl, input logic f, input logic e,
                     input logic af, input logic ae, input logic rv, input logic [7:0] rdat);
    string n;
    n = $sformatf("u%0d", d);
    check({n, ".level"}, lvl, mcnt[d]);
    check({n, ".full"}, f, mcnt[d] == mdep[d]);
    check({n, ".empty"}, e, mcnt[d] == 0);
    check({n, ".almost_full"}, af, mcnt[d] >= maf[d]);
    check({n, ".almost_empty"}, ae, mcnt[d] <= mae[d]);
    if (d == 2) begin
      check({n, ".rd_valid"}, rv, c_exp_v);
      check({n, ".rd_data"}, rdat, c_exp_d);
    end else begin
      check({n, ".rd_valid"}, rv, mcnt[d] > 0);
      if (mcnt[d] > 0) check({n, ".rd_data"}, rdat, mdat[d][0]);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, int'(a_level), a_full, a_empty, a_af, a_ae, a_rd_valid, a_rd_data);
      cmp(1, int'(b_level), b_full, b_empty, b_af, b_ae, b_rd_valid, b_rd_data);
      cmp(2, int'(c_level), c_full, c_empty, c_af, c_ae, c_rd_valid, c_rd_data);
`ifdef UART_FIFO_ERR_FLAGS_EN
      check("u0.overflow", a_ovf, m_ovf[0]);
      check("u1.overflow", b_ovf, m_ovf[1]);
      check("u2.overflow", c_ovf, m_ovf[2]);
      check("u0.underflow", a_unf, m_unf[0]);
      check("u1.underflow", b_unf, m_unf[1]);
      check("u2.underflow", c_unf, m_unf[2]);
`endif
    end
  end

  // Drive one cycle of inputs, update the model at the edge, return at the next negedge.
  task automatic step(input logic f, input logic w, input logic [7:0] wd,
                      input logic r, input logic ec);
    flush   = f;
    wr_en   = w;
    wr_data = wd;
    rd_en   = r;
    err_clr = ec;
    @(posedge clk);
    if (rst_n) model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_flush();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [7:0] wd);
    step(1'b0, 1'b1, wd, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int pw, pr;
    mdep = '{5, 16, 7};
    maf  = '{4, 12, 6};
    mae  = '{1, 4, 2};
    rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    err_clr = 1'b0; wr_data = 8'h00;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset.a_empty", a_empty, 1'b1);
    check("reset.a_almost_empty", a_ae, 1'b1);
    check("reset.c_rd_data", c_rd_data, 8'h00);
    rst_n = 1'b1;

    // Fill DEPTH 5 past capacity, then drain in order.
    do_flush();
    for (int i = 0; i < 6; i++) push(8'h11 + 8'(i));
    check("t1.level", a_level, 3'd5);
    check("t1.full", a_full, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("t1.order", a_rd_data, 8'h11 + 8'(i));
      pop();
    end
    check("t1.empty", a_empty, 1'b1);

    // Pointer wrap on a non-power-of-two depth.
    do_flush();
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < 3; k++) push(8'hA0 + 8'(4 * n + k));
      for (int k = 0; k < 3; k++) begin
        check("t2.order", a_rd_data, 8'hA0 + 8'(4 * n + k));
        pop();
      end
    end

    // Watermarks on DEPTH 16, then full-with-read+write.
    do_flush();
    for (int i = 0; i < 11; i++) push(8'(i));
    check("t3.af_at_11", b_af, 1'b0);
    push(8'd11);
    check("t3.af_at_12", b_af, 1'b1);
    for (int i = 12; i < 16; i++) push(8'(i));
    check("t4.full", b_full, 1'b1);
    step(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
    check("t4.level_15", b_level, 5'd15);
    check("t4.head", b_rd_data, 8'd1);
    for (int i = 0; i < 10; i++) pop();
    check("t3.ae_at_5", b_ae, 1'b0);
    pop();
    check("t3.ae_at_4", b_ae, 1'b1);

    // Empty with read+write stores the write and ignores the read.
    do_flush();
    step(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0);
    check("t4.level_1", b_level, 5'd1);
    check("t4.head_5a", b_rd_data, 8'h5A);

    // Registered-output read pulse.
    do_flush();
    push(8'h3C);
    pop();
    check("t5.rd_valid", c_rd_valid, 1'b1);
    check("t5.rd_data", c_rd_data, 8'h3C);
    idle();
    check("t5.rd_valid_drop", c_rd_valid, 1'b0);

    // Flush wins over a concurrent write.
    do_flush();
    for (int i = 0; i < 7; i++) push(8'h70 + 8'(i));
    check("t6.level_7", b_level, 5'd7);
    step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
    check("t6.level_0", b_level, 5'd0);
    check("t6.empty", b_empty, 1'b1);
`ifdef UART_FIFO_ERR_FLAGS_EN
    pop();
    check("t6.underflow", b_unf, 1'b1);
    idle();
    check("t6.underflow_sticky", b_unf, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("t6.underflow_clr", b_unf, 1'b0);
`endif

    // Asynchronous reset in the middle of a read pulse.
    for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i));
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b1; err_clr = 1'b0;
    @(posedge clk);
    model_update();
    #2;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check("t7.level", a_level, 3'd0);
    check("t7.c_rd_valid", c_rd_valid, 1'b0);
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic, alternating fill-biased and drain-biased phases.
    for (int ph = 0; ph < 8; ph++) begin
      pw = (ph % 2 == 0) ? 80 : 30;
      pr = (ph % 2 == 0) ? 30 : 80;
      for (int i = 0; i < 300; i++)
        step($urandom_range(0, 59) == 0, $urandom_range(0, 99) < pw, 8'($urandom),
             $urandom_range(0, 99) < pr, $urandom_range(0, 29) == 0);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
